k12a_fetch_seq: RTL and testbench
=================================

Name: k12a_fetch_seq

Overview:
- Instruction fetch sequencer directly downstream of the skip register. It consumes the `skip` flag and discards the next instruction when `skip` is set.
- Fetches each 16-bit instruction as two bytes over an 8-bit memory read handshake and presents it to the execute stage.
- When discarding a long instruction, also discards its immediate bytes.
- Drives `skip_clear`, which the control unit maps to `skip_store=1` with `skip_sel=SKIP_SEL_0`.

Parameters:
- LONG_OPCODE, 4'hF, value of instr[15:12] that marks a long instruction followed by immediate bytes.
- LONG_IMM_BYTES, 2, number of immediate bytes after a long instruction; legal range 1..3.

Ports:
- cpu_clock  input  1  CPU clock; all state updates on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- skip  input  1  current skip register value.
- mem_rdata  input  8  memory read data; valid when mem_ready=1.
- mem_ready  input  1  memory has completed the read requested this cycle.
- mem_read  output  1  request read of byte at current PC.
- pc_inc  output  1  PC advance strobe; exactly (mem_read & mem_ready).
- instr  output  16  instruction register; {hi byte, lo byte}.
- instr_valid  output  1  instr is valid and owned by the execute stage.
- exec_done  input  1  execute stage has finished instr; sampled only in EXEC.
- skip_clear  output  1  one-cycle request to clear the skip register.

Behaviour:
- States: FETCH_HI, FETCH_LO, EXEC, SKIP_IMM. A 2-bit down-counter `imm_left` tracks remaining immediate bytes.
- Accept: a cycle with mem_read=1 and mem_ready=1. The byte is latched on that edge and pc_inc=1 in the same cycle.
- FETCH_HI:
  - mem_read=1.
  - On accept: instr[15:8]<=mem_rdata, then go to FETCH_LO.
  - Without accept: hold; mem_read stays high; no timeout.
- FETCH_LO:
  - mem_read=1.
  - On accept with skip=0: instr[7:0]<=mem_rdata, then go to EXEC.
  - On accept with skip=1:
    - instr[7:0] is still loaded; instr_valid stays 0.
    - skip_clear=1 combinationally in that same cycle.
    - If instr[15:12]==LONG_OPCODE: imm_left<=LONG_IMM_BYTES, then go to SKIP_IMM.
    - Otherwise go to FETCH_HI.
  - skip is sampled only on the FETCH_LO accept cycle. Changes of skip at any other time are ignored.
- EXEC:
  - instr_valid=1, mem_read=0, instr held stable.
  - exec_done=1 → FETCH_HI next cycle. Zero-length EXEC is impossible; minimum EXEC residency is 1 cycle.
  - A long instruction that is not skipped stays in EXEC; the execute stage fetches its own immediate.
- SKIP_IMM:
  - mem_read=1; data discarded; instr unchanged.
  - Each accept decrements imm_left.
  - Accept with imm_left==1 → FETCH_HI.
- Latency (mem_ready tied 1, no skip): FETCH_HI→FETCH_LO→EXEC, so instr_valid rises 2 cycles after entering FETCH_HI.
- skip_clear:
  - Never asserted outside a FETCH_LO accept cycle.
  - Never asserted twice for one instruction.
  - Asserted regardless of short or long instruction.
- Back-to-back skips: the cleared skip register is seen as 0 at the next FETCH_LO, unless the control unit re-sets it. In that case the following instruction is also skipped.
- Reset (reset_n=0 at a rising edge):
  - state<=FETCH_HI, instr<=16'h0000, imm_left<=0.
  - While reset_n=0, mem_read, pc_inc, instr_valid and skip_clear are forced to 0 combinationally.
  - Reset mid-SKIP_IMM or mid-EXEC abandons the operation with no further pc_inc.
- exec_done outside EXEC: ignored, no state change.

Optional Feature:
- Macro: K12A_FETCH_STALL_CNT_EN.
- Defined:
  - Adds output port `stall_count` (16 bits).
  - Increments by 1 on each cycle with mem_read=1 and mem_ready=0.
  - Saturates at 16'hFFFF and resets to 0 synchronously.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, mem_ready=1, bytes 8'h12, 8'h34, skip=0 → instr=16'h1234, instr_valid=1 on 3rd cycle after reset release, pc_inc high exactly 2 cycles.
- Same fetch with mem_ready low 3 cycles during FETCH_LO → mem_read held, no pc_inc during stall, instr=16'h1234 one cycle after mem_ready returns. With macro defined, stall_count=3.
- skip=1, bytes 8'h21, 8'h00 → skip_clear pulses 1 cycle on lo accept, instr_valid never rises, next FETCH_HI follows, total pc_inc=2.
- skip=1, bytes 8'hF0, 8'h00, 8'hAA, 8'hBB → skip_clear 1 cycle, 4 pc_inc pulses, next instruction fetched from 5th byte, instr_valid stays 0 throughout.
- Long instruction 16'hF123 with skip=0 → EXEC with instr=16'hF123, no SKIP_IMM, exec_done after 5 cycles → FETCH_HI next cycle.
- reset_n driven low for 1 cycle during SKIP_IMM with imm_left=1 → next cycle state FETCH_HI, instr=16'h0000, all strobes 0 during the reset cycle.

Source files
------------

// File: rtl/k12a_fetch_seq.sv
// k12a_fetch_seq: instruction fetch sequencer downstream of the skip register.
// Fetches a 16-bit instruction as two bytes (hi then lo) over an 8-bit read
// handshake and hands it to the execute stage. If skip is set when the lo
// byte lands, the instruction (plus immediate bytes of a long instruction)
// is discarded and skip_clear is pulsed.
// Optional: define K12A_FETCH_STALL_CNT_EN to add a saturating stall_count
// output counting cycles with mem_read=1 and mem_ready=0.
module k12a_fetch_seq #(
   parameter logic [3:0] LONG_OPCODE    = 4'hF,
   parameter int         LONG_IMM_BYTES = 2
) (
   input  logic        cpu_clock,
   input  logic        reset_n,
   input  logic        skip,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic        mem_read,
   output logic        pc_inc,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        exec_done,
   output logic        skip_clear
`ifdef K12A_FETCH_STALL_CNT_EN
   ,
   output logic [15:0] stall_count
`endif
);

   typedef enum logic [1:0] {
      FETCH_HI = 2'd0,
      FETCH_LO = 2'd1,
      EXEC     = 2'd2,
      SKIP_IMM = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] instr_q, instr_d;
   logic [1:0]  imm_left_q, imm_left_d;

   // State register; reset abandons any fetch, execute or immediate discard.
   always_ff @(posedge cpu_clock) begin
      if (!reset_n) begin
         state_q    <= FETCH_HI;
         instr_q    <= 16'h0000;
         imm_left_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         imm_left_q <= imm_left_d;
      end
   end

   // Next-state and strobes; everything is suppressed while reset is held.
   always_comb begin
      state_d     = state_q;
      instr_d     = instr_q;
      imm_left_d  = imm_left_q;
      mem_read    = 1'b0;
      instr_valid = 1'b0;
      skip_clear  = 1'b0;
      case (state_q)
         FETCH_HI: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               instr_d[15:8] = mem_rdata;
               state_d       = FETCH_LO;
            end
         end
         FETCH_LO: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               // lo byte is loaded even when the instruction is being dropped
               instr_d[7:0] = mem_rdata;
               if (skip) begin
                  skip_clear = 1'b1;
                  if (instr_q[15:12] == LONG_OPCODE) begin
                     imm_left_d = 2'(LONG_IMM_BYTES);
                     state_d    = SKIP_IMM;
                  end else begin
                     state_d = FETCH_HI;
                  end
               end else begin
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            // a non-skipped long instruction stays here; execute fetches its immediate
            instr_valid = 1'b1;
            if (exec_done) state_d = FETCH_HI;
         end
         SKIP_IMM: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               imm_left_d = imm_left_q - 2'd1;
               if (imm_left_q == 2'd1) state_d = FETCH_HI;
            end
         end
         default: state_d = FETCH_HI;
      endcase
      if (!reset_n) begin
         mem_read    = 1'b0;
         instr_valid = 1'b0;
         skip_clear  = 1'b0;
      end
   end

   assign pc_inc = mem_read & mem_ready;
   assign instr  = instr_q;

`ifdef K12A_FETCH_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   // Saturating count of read cycles where memory was not ready.
   always_comb begin
      stall_d = stall_q;
      if (mem_read && !mem_ready && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
   end

   // Stall counter register.
   always_ff @(posedge cpu_clock) begin
      if (!reset_n) stall_q <= 16'h0000;
      else          stall_q <= stall_d;
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_k12a_fetch_seq.sv
// Testbench for k12a_fetch_seq: vector table, directed corner sequences,
// and randomized traffic against a byte-stream reference model.
module tb_k12a_fetch_seq;

   logic        cpu_clock = 1'b0;
   logic        reset_n = 1'b0, skip = 1'b0, mem_ready = 1'b0, exec_done = 1'b0;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_read, pc_inc, instr_valid, skip_clear;
   logic [15:0] instr;
`ifdef K12A_FETCH_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   int checks = 0;
   int failures = 0;

   k12a_fetch_seq dut (
      .cpu_clock   (cpu_clock),
      .reset_n     (reset_n),
      .skip        (skip),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready),
      .mem_read    (mem_read),
      .pc_inc      (pc_inc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .exec_done   (exec_done),
      .skip_clear  (skip_clear)
`ifdef K12A_FETCH_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   always #5 cpu_clock = ~cpu_clock;

   typedef struct {
      logic       rst_n, skp, rdy, done;
      logic [7:0] d;
      logic       mr, pc, iv, sc;
      logic [15:0] ins;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic mr, input logic pc, input logic iv,
                          input logic sc, input logic [15:0] ins);
      chk({tag, ".mem_read"},    32'(mem_read),    32'(mr));
      chk({tag, ".pc_inc"},      32'(pc_inc),      32'(pc));
      chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(iv));
      chk({tag, ".skip_clear"},  32'(skip_clear),  32'(sc));
      chk({tag, ".instr"},       32'(instr),       32'(ins));
   endtask

   // one cycle: drive just after the rising edge, return at the falling edge
   task automatic cyc(input logic r, input logic s, input logic rdy,
                      input logic [7:0] d, input logic dn);
      @(posedge cpu_clock);
      #1;
      reset_n = r; skip = s; mem_ready = rdy; mem_rdata = d; exec_done = dn;
      @(negedge cpu_clock);
   endtask

   // reference model: byte stream with discard count, not a state machine copy
   bit          m_busy, m_have_hi;
   int          m_disc;
   logic [15:0] m_instr;
   int          m_stall;

   initial begin
      int pcs;
      // reset and short skip / plain fetch vectors
      //            rst skp rdy dn  data   mr pc iv sc instr
      vt[0]  = '{1'b0,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,16'h0000};
      vt[1]  = '{1'b1,1'b0,1'b1,1'b0,8'h12, 1'b1,1'b1,1'b0,1'b0,16'h0000};
      vt[2]  = '{1'b1,1'b0,1'b1,1'b0,8'h34, 1'b1,1'b1,1'b0,1'b0,16'h1200};
      vt[3]  = '{1'b1,1'b0,1'b1,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b0,16'h1234};
      vt[4]  = '{1'b1,1'b0,1'b1,1'b1,8'h00, 1'b0,1'b0,1'b1,1'b0,16'h1234};
      vt[5]  = '{1'b1,1'b1,1'b1,1'b0,8'h21, 1'b1,1'b1,1'b0,1'b0,16'h1234};
      vt[6]  = '{1'b1,1'b1,1'b1,1'b0,8'h00, 1'b1,1'b1,1'b0,1'b1,16'h2134};
      vt[7]  = '{1'b1,1'b1,1'b1,1'b0,8'h56, 1'b1,1'b1,1'b0,1'b0,16'h2100};
      vt[8]  = '{1'b1,1'b0,1'b1,1'b0,8'h78, 1'b1,1'b1,1'b0,1'b0,16'h5600};
      vt[9]  = '{1'b1,1'b1,1'b1,1'b1,8'h00, 1'b0,1'b0,1'b1,1'b0,16'h5678};
      vt[10] = '{1'b1,1'b0,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,16'h5678};

      cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      for (int i = 0; i < 11; i++) begin
         cyc(vt[i].rst_n, vt[i].skp, vt[i].rdy, vt[i].d, vt[i].done);
         chk_out($sformatf("vec%0d", i), vt[i].mr, vt[i].pc, vt[i].iv, vt[i].sc, vt[i].ins);
      end

      // A: 3-cycle memory stall during the lo byte
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 8'h12, 1'b0); chk_out("A.hi", 1, 1, 0, 0, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 8'h34, 1'b0); chk_out("A.stall", 1, 0, 0, 0, 16'h1200);
      end
      cyc(1'b1, 1'b0, 1'b1, 8'h34, 1'b0); chk_out("A.lo", 1, 1, 0, 0, 16'h1200);
`ifdef K12A_FETCH_STALL_CNT_EN
      chk("A.stall_count", 32'(stall_count), 32'd3);
`endif
      cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b1); chk_out("A.exec", 0, 0, 1, 0, 16'h1234);

      // B: skipped long instruction discards its two immediate bytes
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      pcs = 0;
      cyc(1'b1, 1'b1, 1'b1, 8'hF0, 1'b0); chk_out("B.b0", 1, 1, 0, 0, 16'h0000); pcs += int'(pc_inc);
      cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0); chk_out("B.b1", 1, 1, 0, 1, 16'hF000); pcs += int'(pc_inc);
      cyc(1'b1, 1'b1, 1'b1, 8'hAA, 1'b0); chk_out("B.b2", 1, 1, 0, 0, 16'hF000); pcs += int'(pc_inc);
      cyc(1'b1, 1'b1, 1'b1, 8'hBB, 1'b0); chk_out("B.b3", 1, 1, 0, 0, 16'hF000); pcs += int'(pc_inc);
      chk("B.pc_inc_count", 32'(pcs), 32'd4);
      cyc(1'b1, 1'b1, 1'b1, 8'h11, 1'b0); chk_out("B.next_hi", 1, 1, 0, 0, 16'hF000);
      cyc(1'b1, 1'b0, 1'b1, 8'h22, 1'b0); chk_out("B.next_lo", 1, 1, 0, 0, 16'h1100);
      cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b1); chk_out("B.exec", 0, 0, 1, 0, 16'h1122);

      // C: long instruction not skipped stays in EXEC until exec_done
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 8'hF1, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 8'h23, 1'b0); chk_out("C.lo", 1, 1, 0, 0, 16'hF100);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b0); chk_out("C.exec", 0, 0, 1, 0, 16'hF123);
      end
      cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b1); chk_out("C.done", 0, 0, 1, 0, 16'hF123);
      cyc(1'b1, 1'b0, 1'b1, 8'h99, 1'b0); chk_out("C.fetch_hi", 1, 1, 0, 0, 16'hF123);

      // D: reset in SKIP_IMM with one immediate byte left
      cyc(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 8'hF0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 8'hBB, 1'b0); chk_out("D.rst", 0, 0, 0, 0, 16'hF000);
      cyc(1'b1, 1'b0, 1'b1, 8'h12, 1'b0); chk_out("D.hi", 1, 1, 0, 0, 16'h0000);
      cyc(1'b1, 1'b0, 1'b1, 8'h34, 1'b0); chk_out("D.lo", 1, 1, 0, 0, 16'h1200);
      cyc(1'b1, 1'b0, 1'b1, 8'h00, 1'b1); chk_out("D.exec", 0, 0, 1, 0, 16'h1234);

      // randomized traffic against the model
      for (int n = 0; n < 800; n++) begin
         logic r, s, rdy, dn, e_mr, e_pc, e_iv, e_sc;
         logic [7:0] d;
         r   = (n == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
         s   = 1'($urandom_range(0, 1));
         rdy = ($urandom_range(0, 9) < 7);
         dn  = ($urandom_range(0, 9) < 3);
         d   = 8'($urandom);
         if ($urandom_range(0, 3) == 0) d[7:4] = 4'hF;
         cyc(r, s, rdy, d, dn);
         e_mr = r && !m_busy;
         e_pc = e_mr && rdy;
         e_iv = r && m_busy;
         e_sc = e_pc && m_disc == 0 && m_have_hi && s;
         if (n > 0) begin
            chk_out("rand", e_mr, e_pc, e_iv, e_sc, m_instr);
`ifdef K12A_FETCH_STALL_CNT_EN
            chk("rand.stall_count", 32'(stall_count), 32'(m_stall));
`endif
         end
         if (!r) begin
            m_busy = 0; m_have_hi = 0; m_disc = 0; m_instr = 16'h0000; m_stall = 0;
         end else begin
            if (m_busy && dn) m_busy = 0;
            if (e_pc) begin
               if (m_disc > 0) m_disc--;
               else if (!m_have_hi) begin
                  m_instr[15:8] = d; m_have_hi = 1;
               end else begin
                  m_instr[7:0] = d; m_have_hi = 0;
                  if (s) m_disc = (m_instr[15:12] == 4'hF) ? 2 : 0;
                  else   m_busy = 1;
               end
            end
            if (e_mr && !rdy && m_stall < 65535) m_stall++;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
